// File: rtl/vdc_vram_arbiter_if.sv
// VRAM arbiter bundle: display fetch inputs, CPU and DMA request ports, VRAM bus.
// The arbiter uses the slave modport; the environment driving it uses master.
interface vdc_vram_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic [2:0]    char_cycle;
  logic          bg_active;
  logic [AW-1:0] bg_addr;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;

  logic [AW-1:0] MA;
  logic [DW-1:0] MD_out;
  logic [DW-1:0] MD_in;
  logic          vram_re;
  logic          vram_we;
  logic          busy_n;

  modport slave (
    input  char_cycle, bg_active, bg_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output MA, MD_out, vram_re, vram_we, busy_n,
    input  MD_in
  );

  modport master (
    output char_cycle, bg_active, bg_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  MA, MD_out, vram_re, vram_we, busy_n,
    output MD_in
  );
endinterface

// File: rtl/vdc_vram_arbiter.sv
// Slot-based VRAM arbiter: display fetch owns fixed slots of the character cycle,
// CPU (priority) and DMA share the rest, one transaction outstanding at a time.
module vdc_vram_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input logic               clock,
  input logic               reset_N,
  vdc_vram_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StPend, StRdWait} state_e;
  typedef enum logic {OwnCpu, OwnDma} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;

  logic          bg_slot;
  logic [AW-1:0] ma;
  logic [DW-1:0] md_out;
  logic          vram_re;
  logic          vram_we;

  assign bg_slot = bus_io.bg_active &&
                   (bus_io.char_cycle == 3'd1 || bus_io.char_cycle == 3'd5 ||
                    bus_io.char_cycle == 3'd7);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    ma          = '0;
    md_out      = '0;
    vram_re     = 1'b0;
    vram_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A port's req is still high during its own ack cycle; ignore it there.
        if (bus_io.cpu_req && !cpu_ack_q) begin
          owner_d = OwnCpu;
          addr_d  = bus_io.cpu_addr;
          wdata_d = bus_io.cpu_wdata;
          we_d    = bus_io.cpu_we;
          state_d = StPend;
        end else if (bus_io.dma_req && !dma_ack_q) begin
          owner_d = OwnDma;
          addr_d  = bus_io.dma_addr;
          wdata_d = bus_io.dma_wdata;
          we_d    = bus_io.dma_we;
          state_d = StPend;
        end
      end
      StPend: begin
        if (!bg_slot) begin
          ma = addr_q;
          if (we_q) begin
            vram_we = 1'b1;
            md_out  = wdata_q;
            state_d = StIdle;
            if (owner_q == OwnCpu) cpu_ack_d = 1'b1;
            else                   dma_ack_d = 1'b1;
          end else begin
            vram_re = 1'b1;
            state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        // Read data returns one cycle after issue regardless of who owns this slot.
        state_d = StIdle;
        if (owner_q == OwnCpu) begin
          cpu_rdata_d = bus_io.MD_in;
          cpu_ack_d   = 1'b1;
        end else begin
          dma_rdata_d = bus_io.MD_in;
          dma_ack_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bg_slot) begin
      ma      = bus_io.bg_addr;
      md_out  = '0;
      vram_re = 1'b1;
      vram_we = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q     <= StIdle;
      owner_q     <= OwnCpu;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign bus_io.MA        = ma;
  assign bus_io.MD_out    = md_out;
  assign bus_io.vram_re   = vram_re;
  assign bus_io.vram_we   = vram_we;
  assign bus_io.cpu_ack   = cpu_ack_q;
  assign bus_io.dma_ack   = dma_ack_q;
  assign bus_io.cpu_rdata = cpu_rdata_q;
  assign bus_io.dma_rdata = dma_rdata_q;
  assign bus_io.busy_n    = !((state_q != StIdle) || cpu_ack_q || dma_ack_q);

endmodule
